// File: rtl/alu_mul_sequencer_if.sv
// Bundle between core, multiply sequencer and the shared ALU.
// slave = sequencer side, master = core/ALU side.
interface alu_mul_sequencer_if #(
  parameter int W = 8
);
  logic           start;
  logic           mul_signed;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  logic [W-1:0]   core_in1;
  logic [W-1:0]   core_in2;
  logic [1:0]     core_alu_op;
  logic [1:0]     core_branch_sel;
  logic           core_sub;
  logic           core_branch;
  logic           core_shift_left;

  logic [W-1:0]   alu_in1;
  logic [W-1:0]   alu_in2;
  logic [1:0]     alu_op;
  logic [1:0]     alu_branch_sel;
  logic           alu_sub;
  logic           alu_branch;
  logic           alu_shift_left;
  logic [W-1:0]   alu_out;

  modport slave (
    input  start, mul_signed, op_a, op_b,
    output busy, done, product,
    input  core_in1, core_in2, core_alu_op,
    input  core_branch_sel, core_sub,
    input  core_branch, core_shift_left,
    output alu_in1, alu_in2, alu_op,
    output alu_branch_sel, alu_sub,
    output alu_branch, alu_shift_left,
    input  alu_out
  );

  modport master (
    output start, mul_signed, op_a, op_b,
    input  busy, done, product,
    output core_in1, core_in2, core_alu_op,
    output core_branch_sel, core_sub,
    output core_branch, core_shift_left,
    input  alu_in1, alu_in2, alu_op,
    input  alu_branch_sel, alu_sub,
    input  alu_branch, alu_shift_left,
    output alu_out
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add WxW multiplier borrowing the shared ALU.
// ALU_MUL_SIGNED_EN adds the signed FIXA/FIXB correction.
module alu_mul_sequencer #(
  parameter int W = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_mul_sequencer_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

`ifdef ALU_MUL_SIGNED_EN
  typedef enum logic [1:0] {
    IDLE, MUL, FIXA, FIXB
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, MUL
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [W-1:0]   acc_hi_q, acc_hi_d;
  logic [W-1:0]   acc_lo_q, acc_lo_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic           sgn_q, sgn_d;
  logic           carry;
  logic [2*W:0]   sh;

`ifndef ALU_MUL_SIGNED_EN
  logic unused_sgn;
  assign unused_sgn = sgn_q;
`endif

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.product = prod_q;

  // Next state, datapath and ALU ownership mux
  always_comb begin
    state_d  = state_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    prod_d   = prod_q;
    done_d   = 1'b0;
    carry    = 1'b0;
    sh       = '0;

    bus.alu_in1        = bus.core_in1;
    bus.alu_in2        = bus.core_in2;
    bus.alu_op         = bus.core_alu_op;
    bus.alu_branch_sel = bus.core_branch_sel;
    bus.alu_sub        = bus.core_sub;
    bus.alu_branch     = bus.core_branch;
    bus.alu_shift_left = bus.core_shift_left;

    if (state_q != IDLE) begin
      bus.alu_in1        = acc_hi_q;
      bus.alu_in2        = '0;
      bus.alu_op         = 2'b00;
      bus.alu_branch_sel = 2'b00;
      bus.alu_sub        = 1'b0;
      bus.alu_branch     = 1'b0;
      bus.alu_shift_left = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.op_a;
          b_d      = bus.op_b;
          acc_hi_d = '0;
          acc_lo_d = '0;
          cnt_d    = '0;
          sgn_d    = bus.mul_signed;
          state_d  = MUL;
        end
      end
      MUL: begin
        bus.alu_in2 = b_q[cnt_q] ? a_q : '0;
        carry       = (bus.alu_out < acc_hi_q);
        sh          = {carry, bus.alu_out, acc_lo_q} >> 1;
        acc_hi_d    = sh[2*W-1:W];
        acc_lo_d    = sh[W-1:0];
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
`ifdef ALU_MUL_SIGNED_EN
          if (sgn_q) begin
            state_d = FIXA;
          end else begin
            prod_d  = sh[2*W-1:0];
            done_d  = 1'b1;
            state_d = IDLE;
          end
`else
          prod_d  = sh[2*W-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end
      end
`ifdef ALU_MUL_SIGNED_EN
      FIXA: begin
        bus.alu_in2 = a_q[W-1] ? b_q : '0;
        bus.alu_sub = 1'b1;
        acc_hi_d    = bus.alu_out;
        state_d     = FIXB;
      end
      FIXB: begin
        bus.alu_in2 = b_q[W-1] ? a_q : '0;
        bus.alu_sub = 1'b1;
        acc_hi_d    = bus.alu_out;
        prod_d      = {bus.alu_out, acc_lo_q};
        done_d      = 1'b1;
        state_d     = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
    end
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a
// behavioural ALU and integer-arithmetic product model.
module tb_alu_mul_sequencer;
`ifdef ALU_MUL_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  typedef struct {
    logic [15:0] p;
    int          c0;
    bit          s;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;
  exp_t sb[$];

  alu_mul_sequencer_if #(.W(8)) bus();

  alu_mul_sequencer #(.W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shared ALU
  always_comb begin
    bus.alu_out = '0;
    if (bus.alu_branch) begin
      case (bus.alu_branch_sel)
        2'b00: bus.alu_out = {7'd0, bus.alu_in1 == bus.alu_in2};
        2'b01: bus.alu_out = {7'd0, bus.alu_in1 <  bus.alu_in2};
        2'b10: bus.alu_out = {7'd0, bus.alu_in1 != bus.alu_in2};
        default: bus.alu_out = {7'd0, bus.alu_in1 >= bus.alu_in2};
      endcase
    end else begin
      case (bus.alu_op)
        2'b00: bus.alu_out = bus.alu_sub
                           ? bus.alu_in1 - bus.alu_in2
                           : bus.alu_in1 + bus.alu_in2;
        2'b01: bus.alu_out = bus.alu_in1 & bus.alu_in2;
        2'b10: bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
        default: bus.alu_out = bus.alu_shift_left
                             ? bus.alu_in1 << bus.alu_in2[2:0]
                             : bus.alu_in1 >> bus.alu_in2[2:0];
      endcase
    end
  end

  function automatic logic [15:0] ref_mul(
    input logic [7:0] a, input logic [7:0] b, input bit s
  );
    int ia;
    int ib;
    int p;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    p  = ia * ib;
    return p[15:0];
  endfunction

  task automatic check(
    input string nm, input int act, input int exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got product 0x%0h expected none",
                 bus.product);
      end else begin
        e = sb.pop_front();
        check("product", int'(bus.product), int'(e.p));
        check("latency", cyc - e.c0, e.s ? 11 : 9);
        check("busy_in_done", int'(bus.busy), 0);
      end
    end
  end

  task automatic rand_core();
    bus.core_in1        = 8'($urandom);
    bus.core_in2        = 8'($urandom);
    bus.core_alu_op     = 2'($urandom);
    bus.core_branch_sel = 2'($urandom);
    bus.core_sub        = 1'($urandom);
    bus.core_branch     = 1'($urandom);
    bus.core_shift_left = 1'($urandom);
  endtask

  task automatic issue(
    input logic [7:0] a, input logic [7:0] b, input bit s
  );
    int g;
    exp_t e;
    g = 0;
    @(negedge clk);
    while (bus.busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      tests++;
      fails++;
      $display("FAIL idle_wait: got busy=1 expected 0");
    end
    rand_core();
    bus.op_a       = a;
    bus.op_b       = b;
    bus.mul_signed = s;
    bus.start      = 1'b1;
    e.p  = ref_mul(a, b, s && SEN);
    e.c0 = cyc;
    e.s  = s && SEN;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rand_core();
    check("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic mirror_check(input string nm);
    #1;
    check({nm, "_mux"},
          int'({bus.alu_in1, bus.alu_in2, bus.alu_op,
                bus.alu_branch_sel, bus.alu_sub,
                bus.alu_branch, bus.alu_shift_left}),
          int'({bus.core_in1, bus.core_in2, bus.core_alu_op,
                bus.core_branch_sel, bus.core_sub,
                bus.core_branch, bus.core_shift_left}));
    check({nm, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    cyc            = 0;
    rst_n          = 1'b1;
    bus.start      = 1'b0;
    bus.mul_signed = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    rand_core();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_product", int'(bus.product), 0);
    rst_n = 1'b1;

    issue(8'd13, 8'd11, 1'b0);
    issue(8'd255, 8'd255, 1'b0);
    drain();

    bus.core_in1        = 8'd20;
    bus.core_in2        = 8'd5;
    bus.core_alu_op     = 2'b00;
    bus.core_sub        = 1'b1;
    bus.core_branch     = 1'b1;
    bus.core_branch_sel = 2'b01;
    bus.core_shift_left = 1'b0;
    mirror_check("idle_fixed");
    check("idle_alu_out", int'(bus.alu_out), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rand_core();
      mirror_check("idle_rand");
    end

    issue(8'd13, 8'd11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.op_a  = 8'd2;
    bus.op_b  = 8'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    issue(8'd3, 8'd4, 1'b0);
    drain();

    issue(8'd9, 8'd9, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_product", int'(bus.product), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd7, 8'd6, 1'b0);
    drain();

    issue(8'hFD, 8'd5, 1'b1);
    issue(8'h80, 8'h80, 1'b1);
    issue(8'hFF, 8'h7F, 1'b1);
    drain();

    for (int i = 0; i < 30; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
